counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin a count sequence.
REQ-005 The block SHALL have port stop, input, 1, an abort that returns the block to idle.
REQ-006 The block SHALL have port pause, input, 1, a level that freezes counting while high.
REQ-007 The block SHALL have port tick, input, 1, a count-enable strobe; one increment per cycle with tick=1.
REQ-008 The block SHALL have port auto_reload, input, 1, a mode select: 1 = periodic, 0 = one-shot; sampled with start.
REQ-009 The block SHALL have port limit, input, WIDTH, the terminal count; sampled with start.
REQ-010 The block SHALL have port count, output, WIDTH, the current count value.
REQ-011 The block SHALL have port busy, output, 1, which is high in RUN and HOLD.
REQ-012 The block SHALL have port done, output, 1, a one-cycle pulse at terminal count.
REQ-013 The block SHALL have port state, output, 2, the current FSM state.

Function
REQ-014 The FSM SHALL use states IDLE=00, RUN=01, HOLD=10 and DONE=11.
REQ-015 All outputs SHALL be registered, with no combinational path from input to output.
REQ-016 Same-cycle input priority SHALL be stop > start > pause > tick.
REQ-017 stop=1 in any state SHALL force IDLE and count=0 on the next edge; done SHALL not pulse.
REQ-018 In IDLE or DONE, start=1 SHALL latch limit and auto_reload, clear count to 0, and enter RUN on the next edge.
REQ-019 start SHALL be ignored in RUN and HOLD; limit and auto_reload changes during a sequence SHALL have no effect.
REQ-020 In RUN with tick=1 and count<limit_q, count SHALL increment by 1 on the next edge.
REQ-021 In RUN with tick=1 and count==limit_q, done SHALL be 1 in the next cycle only.
REQ-022 In that terminal case with auto_reload_q=1, count SHALL wrap to 0 and the state SHALL remain RUN.
REQ-023 In that terminal case with auto_reload_q=0, count SHALL hold limit_q and the state SHALL enter DONE.
REQ-024 count SHALL never exceed limit_q and SHALL never wrap modulo 2^WIDTH.
REQ-025 In RUN with pause=1, the block SHALL enter HOLD with count frozen; a tick in the same cycle SHALL be ignored.
REQ-026 In HOLD with pause=0, the block SHALL return to RUN; ticks SHALL be ignored while in HOLD.
REQ-027 limit_q=0 SHALL give done on every accepted tick in RUN, with count staying 0.
REQ-028 tick SHALL be ignored in IDLE and DONE; DONE SHALL hold count until start or stop.
REQ-029 Latency SHALL be: start at edge n gives state=RUN after edge n; the first increment occurs at the first tick edge after that.

Reset
REQ-030 reset=1 at a clock edge SHALL set state=IDLE, count=0, busy=0, done=0, limit_q=0 and auto_reload_q=0.
REQ-031 reset SHALL override stop, start, pause and tick, including when asserted mid-sequence.

Structure
REQ-032 Package counter_ctrl_pkg SHALL hold the state typedef/encoding constants and the default WIDTH.
REQ-033 The counting register SHALL be sub-module sync_up_counter, a synchronous up counter with clear and enable inputs.
REQ-034 Counting SHALL be fully synchronous: no derived or rippled clocks.

Verification
REQ-035 Reset, then start with limit=3, auto_reload=0, and tick held at 1 -> count 0,1,2,3; done pulses once; state=DONE; busy=0.
REQ-036 limit=2, auto_reload=1, tick=1 for 9 cycles -> count 0,1,2,0,1,2,0,1,2; done pulses after each 2.
REQ-037 Pause at count=1 for 4 cycles with tick=1 -> state=HOLD; count stays 1; after pause drops, counting resumes from 1 to 2.
REQ-038 stop and start in the same cycle while in RUN at count=2 -> IDLE, count=0, no done pulse.
REQ-039 limit=0 with alternating tick -> done on each tick cycle +1; count stays 0.
REQ-040 reset asserted mid-RUN at count=5 (WIDTH=4, limit=9) -> all outputs at reset values next cycle; a new start then behaves as REQ-018.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter controller.
package counter_ctrl_pkg;

  // Default counter width in bits.
  localparam int unsigned CounterWidthDefault = 4;

  // FSM state encoding; the values are visible on the state output port.
  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'b00;
  localparam state_t StRun  = 2'b01;
  localparam state_t StHold = 2'b10;
  localparam state_t StDone = 2'b11;

  // A sequence is in progress while running or held.
  function automatic logic state_is_busy(input state_t st);
    return (st == StRun) || (st == StHold);
  endfunction

endpackage

// File: rtl/sync_up_counter.sv
// Synchronous up counter with clear and enable. Clear wins over enable.
module sync_up_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_d, count_q;

  // Next count: clear, increment or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_ctrl.sv
// Start/stop/pause controlled terminal counter with one-shot and periodic modes.
// Every output comes straight from a flop.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CounterWidthDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             tick,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  state_t           state_d, state_q;
  logic [WIDTH-1:0] limit_d, limit_q;
  logic             auto_reload_d, auto_reload_q;
  logic             done_d, done_q;
  logic             busy_d, busy_q;
  logic             cnt_clr, cnt_en;
  logic [WIDTH-1:0] cnt_val;
  logic             at_limit;

  // >= rather than == so a corrupted count can never run past the limit.
  assign at_limit = (cnt_val >= limit_q);

  // Next-state, sequence parameters and counter controls; priority stop > start > pause > tick.
  always_comb begin
    state_d       = state_q;
    limit_d       = limit_q;
    auto_reload_d = auto_reload_q;
    done_d        = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;

    if (stop) begin
      state_d = StIdle;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          // Ticks are ignored here; DONE keeps the terminal count on display.
          if (start) begin
            limit_d       = limit;
            auto_reload_d = auto_reload;
            cnt_clr       = 1'b1;
            state_d       = StRun;
          end
        end
        StRun: begin
          if (pause) begin
            state_d = StHold;
          end else if (tick) begin
            if (at_limit) begin
              done_d = 1'b1;
              if (auto_reload_q) begin
                cnt_clr = 1'b1;
              end else begin
                state_d = StDone;
              end
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        StHold: begin
          // The release cycle itself does not count a tick.
          if (!pause) begin
            state_d = StRun;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_clr = 1'b1;
        end
      endcase
    end

    busy_d = state_is_busy(state_d);
  end

  // Control registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      limit_q       <= '0;
      auto_reload_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      limit_q       <= limit_d;
      auto_reload_q <= auto_reload_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  sync_up_counter #(
    .Width (WIDTH)
  ) u_counter (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cnt_val)
  );

  assign count = cnt_val;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model.
module tb_counter_ctrl;

  localparam int W = 4;

  // Model mode names mapped to the externally visible state code.
  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MHold = 2;
  localparam int MDone = 3;

  logic         clk = 1'b0;
  logic         reset, start, stop, pause, tick, auto_reload;
  logic [W-1:0] limit;
  logic [W-1:0] count;
  logic         busy, done;
  logic [1:0]   state;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  // Behavioural reference state.
  int m_mode = MIdle;
  int m_cnt  = 0;
  int m_lim  = 0;
  bit m_ar   = 0;
  bit m_done = 0;

  counter_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .tick        (tick),
    .auto_reload (auto_reload),
    .limit       (limit),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_step(input bit r, input bit s, input bit stp, input bit p, input bit t,
                            input bit ar, input int lim);
    m_done = 0;
    if (r) begin
      m_mode = MIdle; m_cnt = 0; m_lim = 0; m_ar = 0;
    end else if (stp) begin
      m_mode = MIdle; m_cnt = 0;
    end else if (m_mode == MIdle || m_mode == MDone) begin
      if (s) begin
        m_lim = lim; m_ar = ar; m_cnt = 0; m_mode = MRun;
      end
    end else if (m_mode == MRun) begin
      if (p) begin
        m_mode = MHold;
      end else if (t) begin
        if (m_cnt == m_lim) begin
          m_done = 1;
          if (m_ar) m_cnt = 0;
          else m_mode = MDone;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end else begin
      if (!p) m_mode = MRun;
    end
  endtask

  // Apply inputs for one cycle, advance the model, then compare all outputs.
  task automatic cycle(input bit r, input bit s, input bit stp, input bit p, input bit t,
                       input bit ar, input int lim);
    reset = r; start = s; stop = stp; pause = p; tick = t; auto_reload = ar;
    limit = W'(lim);
    @(posedge clk);
    model_step(r, s, stp, p, t, ar, lim);
    #1;
    if (done === 1'b1) done_seen++;
    check_eq("count", 32'(count), 32'(m_cnt));
    check_eq("state", 32'(state), 32'(m_mode));
    check_eq("busy",  32'(busy),  32'((m_mode == MRun || m_mode == MHold) ? 1 : 0));
    check_eq("done",  32'(done),  32'(m_done));
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; pause = 0; tick = 0; auto_reload = 0; limit = '0;

    cycle(1, 0, 0, 0, 1, 0, 0);
    cycle(1, 1, 0, 0, 1, 1, 7);
    check_eq("reset_state", 32'(state), 32'd0);
    check_eq("reset_count", 32'(count), 32'd0);

    // One-shot to 3 with tick held high.
    cycle(0, 1, 0, 0, 1, 0, 3);
    check_eq("os_start_state", 32'(state), 32'd1);
    check_eq("os_start_count", 32'(count), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 1, 9);
    check_eq("os_done_pulses", 32'(done_seen), 32'd1);
    check_eq("os_final_count", 32'(count), 32'd3);
    check_eq("os_final_state", 32'(state), 32'd3);
    check_eq("os_final_busy",  32'(busy),  32'd0);

    // Periodic with limit 2 for nine ticks: 0,1,2 repeating, done after each 2.
    cycle(0, 1, 0, 0, 0, 1, 2);
    done_seen = 0;
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 1, 0, 5);
    check_eq("ar_done_pulses", 32'(done_seen), 32'd3);
    check_eq("ar_state", 32'(state), 32'd1);

    // Pause at count 1 for four cycles with tick high.
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 7);
    cycle(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, 0, 0);
    check_eq("hold_state", 32'(state), 32'd2);
    check_eq("hold_count", 32'(count), 32'd1);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check_eq("resume_count", 32'(count), 32'd2);

    // Stop and start together at count 2.
    done_seen = 0;
    cycle(0, 1, 1, 0, 1, 0, 0);
    check_eq("stop_state", 32'(state), 32'd0);
    check_eq("stop_count", 32'(count), 32'd0);
    check_eq("stop_no_done", 32'(done_seen), 32'd0);

    // Limit 0 with alternating tick.
    cycle(0, 1, 0, 0, 0, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, (i % 2) == 0, 0, 0);
    check_eq("lim0_done_pulses", 32'(done_seen), 32'd1);
    cycle(0, 1, 0, 0, 0, 1, 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, (i % 2) == 0, 0, 0);
    check_eq("lim0_ar_done_pulses", 32'(done_seen), 32'd4);
    check_eq("lim0_ar_count", 32'(count), 32'd0);

    // Reset mid-run at count 5, then restart.
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 9);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0, 0);
    check_eq("pre_reset_count", 32'(count), 32'd5);
    cycle(1, 1, 0, 1, 1, 1, 4);
    check_eq("mid_reset_count", 32'(count), 32'd0);
    check_eq("mid_reset_state", 32'(state), 32'd0);
    cycle(0, 1, 0, 0, 1, 0, 2);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0, 0);
    check_eq("restart_state", 32'(state), 32'd3);
    check_eq("restart_count", 32'(count), 32'd2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, s, stp, p, t, ar;
      int lim;
      r   = ($urandom_range(0, 199) == 0);
      stp = ($urandom_range(0, 39) == 0);
      s   = ($urandom_range(0, 5) == 0);
      p   = ($urandom_range(0, 4) == 0);
      t   = ($urandom_range(0, 2) != 0);
      ar  = $urandom_range(0, 1) == 1;
      lim = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      cycle(r, s, stp, p, t, ar, lim);
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
